// File: rtl/smc_loop_sched_pkg.sv
// Shared types and helpers for the SMC control-loop sequencer: FSM encoding,
// fixed-point width and the symmetric saturator.
package smc_loop_sched_pkg;

   localparam int QW = 32;
   localparam logic signed [QW-1:0] U_MAX_DEFAULT = 32'sd30000;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SNS = 2'd1,
      ST_SETTLE   = 2'd2,
      ST_CAPTURE  = 2'd3
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bounds themselves pass through unchanged.
   function automatic logic signed [QW-1:0] sat_sym(input logic signed [QW-1:0] x,
                                                    input logic signed [QW-1:0] lim);
      if (x > lim)
         return lim;
      else if (x < -lim)
         return -lim;
      else
         return x;
   endfunction

endpackage

// File: rtl/smc_period_timer.sv
// Control-period timer: counts 0..PERIOD-1 while enabled and flags the last
// count of each period with a one-cycle tick.
module smc_period_timer #(
   parameter int PERIOD = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int TW = $clog2(PERIOD);

   logic [TW-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_reg <= '0;
      else if (!en || count_reg == TW'(PERIOD - 1))
         count_reg <= '0;
      else
         count_reg <= count_reg + 1'b1;
   end

   assign tick = en && (count_reg == TW'(PERIOD - 1));

endmodule

// File: rtl/smc_loop_sched.sv
// Periodic sequencer around an external combinational control law: sensor
// handshake, operand latch, settle wait, saturated capture and timeout watchdog.
module smc_loop_sched
   import smc_loop_sched_pkg::*;
#(
   parameter int                     PERIOD  = 50000,
   parameter int                     SETTLE  = 4,
   parameter int                     TIMEOUT = 1000,
   parameter logic signed [QW-1:0]   U_MAX   = U_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        fault_clr,
   input  logic [31:0] traj_thd,
   input  logic [31:0] traj_dthd,
   input  logic [31:0] traj_ddthd,
   output logic        sns_req,
   input  logic        sns_valid,
   input  logic [31:0] sns_th,
   input  logic [31:0] sns_dth,
   input  logic [31:0] sns_dp,
   output logic [31:0] c_thd,
   output logic [31:0] c_dthd,
   output logic [31:0] c_ddthd,
   output logic [31:0] c_th,
   output logic [31:0] c_dth,
   output logic [31:0] c_dp,
   input  logic [31:0] c_u,
   output logic [31:0] u_out,
   output logic        u_valid,
   output logic        fault,
   output logic [7:0]  overrun
);

   // One counter serves both the watchdog and the settle wait.
   localparam int CW = max_int(1, $clog2(max_int(TIMEOUT, SETTLE)));

   state_t         state_reg, state_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic           fault_reg, fault_next;
   logic [31:0]    u_out_reg, u_out_next;
   logic           u_valid_reg, u_valid_next;
   logic [7:0]     overrun_reg, overrun_next;
   logic           latch;
   logic           tick;
   logic [31:0]    opnd_in  [6];
   logic [31:0]    opnd_reg [6];

   smc_period_timer #(
      .PERIOD (PERIOD)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .tick  (tick)
   );

   assign opnd_in[0] = traj_thd;
   assign opnd_in[1] = traj_dthd;
   assign opnd_in[2] = traj_ddthd;
   assign opnd_in[3] = sns_th;
   assign opnd_in[4] = sns_dth;
   assign opnd_in[5] = sns_dp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 6; i++)
            opnd_reg[i] <= '0;
      end else if (latch) begin
         for (int i = 0; i < 6; i++)
            opnd_reg[i] <= opnd_in[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         fault_reg   <= 1'b0;
         u_out_reg   <= '0;
         u_valid_reg <= 1'b0;
         overrun_reg <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         fault_reg   <= fault_next;
         u_out_reg   <= u_out_next;
         u_valid_reg <= u_valid_next;
         overrun_reg <= overrun_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      fault_next   = fault_reg;
      u_out_next   = u_out_reg;
      u_valid_next = 1'b0;
      overrun_next = overrun_reg;
      latch        = 1'b0;

      // A tick that finds the loop busy is dropped and only counted.
      if (tick && state_reg != ST_IDLE && overrun_reg != 8'hFF)
         overrun_next = overrun_reg + 8'd1;

      if (fault_clr)
         fault_next = 1'b0;

      if (!en) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
         u_out_next = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (tick && !fault_reg) begin
                  state_next = ST_WAIT_SNS;
                  cnt_next   = '0;
               end
            end
            ST_WAIT_SNS: begin
               if (sns_valid) begin
                  latch      = 1'b1;
                  state_next = ST_SETTLE;
                  cnt_next   = '0;
               end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                  fault_next = 1'b1;
                  state_next = ST_IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            ST_SETTLE: begin
               if (cnt_reg == CW'(SETTLE - 1))
                  state_next = ST_CAPTURE;
               else
                  cnt_next = cnt_reg + 1'b1;
            end
            ST_CAPTURE: begin
               u_out_next   = sat_sym($signed(c_u), U_MAX);
               u_valid_next = 1'b1;
               state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end

      // A latched or freshly raised fault pins the command to zero.
      if (fault_next) begin
         u_out_next   = '0;
         u_valid_next = 1'b0;
      end
   end

   assign sns_req = (state_reg == ST_WAIT_SNS);
   assign c_thd   = opnd_reg[0];
   assign c_dthd  = opnd_reg[1];
   assign c_ddthd = opnd_reg[2];
   assign c_th    = opnd_reg[3];
   assign c_dth   = opnd_reg[4];
   assign c_dp    = opnd_reg[5];
   assign u_out   = u_out_reg;
   assign u_valid = u_valid_reg;
   assign fault   = fault_reg;
   assign overrun = overrun_reg;

endmodule

// File: tb/tb_smc_loop_sched.sv
// Scoreboard bench for smc_loop_sched: nominal loop, saturation, timeout,
// overrun, enable drop and asynchronous reset, one task per scenario.
module tb_smc_loop_sched;

   localparam int PERIOD  = 100;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 98;
   localparam int LAT     = SETTLE + 2;

   logic        clk = 1'b0;
   logic        rst_n, en, fault_clr;
   logic [31:0] traj_thd, traj_dthd, traj_ddthd;
   logic        sns_req, sns_valid;
   logic [31:0] sns_th, sns_dth, sns_dp;
   logic [31:0] c_thd, c_dthd, c_ddthd, c_th, c_dth, c_dp, c_u;
   logic [31:0] u_out;
   logic        u_valid, fault;
   logic [7:0]  overrun;

   logic        law_mode;
   logic [31:0] law_const;
   logic [31:0] exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in control law: either thd-th or a forced constant.
   always_comb c_u = law_mode ? law_const : (c_thd - c_th);

   smc_loop_sched #(
      .PERIOD  (PERIOD),
      .SETTLE  (SETTLE),
      .TIMEOUT (TIMEOUT),
      .U_MAX   (32'sd30000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .fault_clr  (fault_clr),
      .traj_thd   (traj_thd),
      .traj_dthd  (traj_dthd),
      .traj_ddthd (traj_ddthd),
      .sns_req    (sns_req),
      .sns_valid  (sns_valid),
      .sns_th     (sns_th),
      .sns_dth    (sns_dth),
      .sns_dp     (sns_dp),
      .c_thd      (c_thd),
      .c_dthd     (c_dthd),
      .c_ddthd    (c_ddthd),
      .c_th       (c_th),
      .c_dth      (c_dth),
      .c_dp       (c_dp),
      .c_u        (c_u),
      .u_out      (u_out),
      .u_valid    (u_valid),
      .fault      (fault),
      .overrun    (overrun)
   );

   task automatic wait_req(input int limit, output bit got);
      got = 1'b0;
      for (int i = 0; i < limit && !got; i++) begin
         @(negedge clk);
         if (sns_req) got = 1'b1;
      end
   endtask

   // Answers d negedges after the current one; returns just after the sampling edge.
   task automatic answer(input int d, input logic [31:0] thd, input logic [31:0] th,
                         input logic [31:0] dp);
      repeat (d) @(negedge clk);
      traj_thd   = thd;
      traj_dthd  = thd + 32'd1;
      traj_ddthd = thd + 32'd2;
      sns_th     = th;
      sns_dth    = th + 32'd5;
      sns_dp     = dp;
      sns_valid  = 1'b1;
      @(posedge clk);
      #1;
      sns_valid  = 1'b0;
      traj_thd   = $urandom();
      traj_dthd  = $urandom();
      traj_ddthd = $urandom();
      sns_th     = $urandom();
      sns_dth    = $urandom();
      sns_dp     = $urandom();
   endtask

   task automatic wait_uvalid(input int limit, output int lat);
      lat = -1;
      for (int i = 1; i <= limit && lat < 0; i++) begin
         @(negedge clk);
         if (u_valid) lat = i;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; en = 1'b0; fault_clr = 1'b0; sns_valid = 1'b0;
      traj_thd = '0; traj_dthd = '0; traj_ddthd = '0;
      sns_th = '0; sns_dth = '0; sns_dp = '0;
      law_mode = 1'b0; law_const = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({sns_req, u_valid, fault} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 000", {sns_req, u_valid, fault});
      end
      n_checks++;
      if (overrun !== 8'd0 || u_out !== 32'd0) begin
         n_fail++; $display("FAIL reset_counts: overrun=%0d u_out=%0h want 0/0", overrun, u_out);
      end
      n_checks++;
      if ((c_thd | c_dthd | c_ddthd | c_th | c_dth | c_dp) !== 32'd0) begin
         n_fail++; $display("FAIL reset_operands: got nonzero c_* want all 0");
      end
      en = 1'b1;
      rst_n = 1'b1;
      $display("reset: released, loop enabled");
   endtask

   task automatic test_nominal;
      logic [31:0] thd_tab [3] = '{32'h500, 32'h80, 32'hFFFFF000};
      logic [31:0] exp_u;
      bit got;
      int lat, prev_cyc;
      law_mode = 1'b0;
      prev_cyc = 0;
      for (int t = 0; t < 3; t++) begin
         wait_req(150, got);
         n_checks++;
         if (!got) begin n_fail++; $display("FAIL nominal_req: got no sns_req want one"); end
         if (t > 0) begin
            n_checks++;
            if (cyc - prev_cyc != PERIOD) begin
               n_fail++; $display("FAIL nominal_period: got %0d want %0d", cyc - prev_cyc, PERIOD);
            end
         end
         prev_cyc = cyc;
         exp_q.push_back(thd_tab[t] - 32'h100);
         answer(2, thd_tab[t], 32'h100, 32'(t + 7));
         n_checks++;
         if (c_thd !== thd_tab[t] || c_th !== 32'h100 || c_dthd !== thd_tab[t] + 32'd1 ||
             c_ddthd !== thd_tab[t] + 32'd2 || c_dth !== 32'h105 || c_dp !== 32'(t + 7)) begin
            n_fail++; $display("FAIL nominal_latch: got thd=%0h th=%0h dp=%0h want %0h/100/%0h",
                               c_thd, c_th, c_dp, thd_tab[t], t + 7);
         end
         n_checks++;
         if (sns_req !== 1'b0) begin n_fail++; $display("FAIL nominal_req_drop: got 1 want 0"); end
         wait_uvalid(20, lat);
         exp_u = exp_q.pop_front();
         n_checks++;
         if (lat != LAT) begin n_fail++; $display("FAIL nominal_latency: got %0d want %0d", lat, LAT); end
         n_checks++;
         if (u_out !== exp_u) begin n_fail++; $display("FAIL nominal_u: got %0h want %0h", u_out, exp_u); end
         n_checks++;
         if (c_thd !== thd_tab[t]) begin
            n_fail++; $display("FAIL nominal_stable: got %0h want %0h", c_thd, thd_tab[t]);
         end
         @(negedge clk);
         n_checks++;
         if (u_valid !== 1'b0) begin n_fail++; $display("FAIL nominal_pulse: got 1 want 0"); end
         $display("nominal: t=%0d thd=%0h u_out=%0h lat=%0d", t, thd_tab[t], u_out, lat);
      end
      // Valid while idle must not disturb the latched operands.
      sns_th = 32'hDEAD; traj_thd = 32'hBEEF; sns_valid = 1'b1;
      @(posedge clk); #1 sns_valid = 1'b0;
      n_checks++;
      if (c_th !== 32'h100 || c_thd !== 32'hFFFFF000) begin
         n_fail++; $display("FAIL idle_valid_ignored: got th=%0h thd=%0h want 100/fffff000", c_th, c_thd);
      end
   endtask

   task automatic test_saturation;
      int sat_in  [5] = '{40000, -40000, 30000, -30000, 29999};
      int sat_exp [5] = '{30000, -30000, 30000, -30000, 29999};
      logic [31:0] exp_u;
      bit got;
      int lat;
      law_mode = 1'b1;
      for (int t = 0; t < 5; t++) begin
         law_const = 32'(sat_in[t]);
         wait_req(150, got);
         exp_q.push_back(32'(sat_exp[t]));
         answer(2, 32'h10, 32'h20, 32'h0);
         wait_uvalid(20, lat);
         exp_u = exp_q.pop_front();
         n_checks++;
         if (!got || lat != LAT || u_out !== exp_u) begin
            n_fail++; $display("FAIL saturation: in=%0d got u=%0d lat=%0d want u=%0d lat=%0d",
                               sat_in[t], $signed(u_out), lat, $signed(exp_u), LAT);
         end
         $display("saturation: c_u=%0d u_out=%0d", sat_in[t], $signed(u_out));
      end
      law_mode = 1'b0;
   endtask

   task automatic test_timeout;
      bit got, seen;
      int c;
      wait_req(150, got);
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL timeout_req: got none want sns_req"); end
      c = 1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!sns_req) break;
         c++;
      end
      n_checks++;
      if (c != TIMEOUT) begin n_fail++; $display("FAIL timeout_len: got %0d want %0d", c, TIMEOUT); end
      n_checks++;
      if (fault !== 1'b1 || u_out !== 32'd0) begin
         n_fail++; $display("FAIL timeout_fault: got fault=%b u=%0h want 1/0", fault, u_out);
      end
      seen = 1'b0;
      repeat (250) begin
         @(negedge clk);
         if (sns_req) seen = 1'b1;
      end
      n_checks++;
      if (seen || fault !== 1'b1) begin
         n_fail++; $display("FAIL fault_blocks_ticks: got req_seen=%b fault=%b want 0/1", seen, fault);
      end
      fault_clr = 1'b1; @(posedge clk); #1 fault_clr = 1'b0;
      n_checks++;
      if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_clr: got 1 want 0"); end
      wait_req(110, got);
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL post_clr_req: got none want sns_req"); end
      // Clear lands on the very edge the watchdog fires: fault must stay set.
      for (int i = 0; i < TIMEOUT - 1; i++) @(negedge clk);
      fault_clr = 1'b1; @(posedge clk); #1 fault_clr = 1'b0;
      n_checks++;
      if (fault !== 1'b1 || sns_req !== 1'b0) begin
         n_fail++; $display("FAIL timeout_beats_clr: got fault=%b req=%b want 1/0", fault, sns_req);
      end
      fault_clr = 1'b1; @(posedge clk); #1 fault_clr = 1'b0;
      $display("timeout: len=%0d fault=%b after final clear", c, fault);
   endtask

   task automatic test_overrun;
      logic [31:0] exp_u;
      bit got;
      int lat, exp_ov;
      exp_ov = 0;
      for (int i = 1; i <= 260; i++) begin
         wait_req(250, got);
         n_checks++;
         if (!got) begin n_fail++; $display("FAIL overrun_req: iter %0d no sns_req", i); break; end
         exp_q.push_back(32'(i * 16) - 32'd3);
         answer(96, 32'(i * 16), 32'd3, 32'd0);
         wait_uvalid(20, lat);
         exp_u = exp_q.pop_front();
         exp_ov = (i > 255) ? 255 : i;
         if (i <= 3 || i >= 254) begin
            n_checks++;
            if (overrun !== 8'(exp_ov) || lat != LAT || u_out !== exp_u) begin
               n_fail++; $display("FAIL overrun: iter %0d got ov=%0d lat=%0d u=%0h want %0d/%0d/%0h",
                                  i, overrun, lat, u_out, exp_ov, LAT, exp_u);
            end
            $display("overrun: iter=%0d overrun=%0d u_out=%0h", i, overrun, u_out);
         end
      end
   endtask

   task automatic test_en_drop;
      logic [31:0] exp_u;
      bit got, seen;
      int lat, n;
      wait_req(250, got);
      answer(2, 32'h777, 32'h100, 32'h0);
      repeat (2) @(negedge clk);
      en = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (sns_req !== 1'b0 || u_out !== 32'd0) begin
         n_fail++; $display("FAIL en_drop_idle: got req=%b u=%0h want 0/0", sns_req, u_out);
      end
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (u_valid) seen = 1'b1;
      end
      n_checks++;
      if (seen || overrun !== 8'd255 || fault !== 1'b0) begin
         n_fail++; $display("FAIL en_drop_kept: got uv_seen=%b ov=%0d fault=%b want 0/255/0",
                            seen, overrun, fault);
      end
      en = 1'b1;
      n = -1;
      for (int i = 1; i <= 150 && n < 0; i++) begin
         @(negedge clk);
         if (sns_req) n = i;
      end
      n_checks++;
      if (n != PERIOD) begin n_fail++; $display("FAIL en_resume: got %0d want %0d", n, PERIOD); end
      exp_q.push_back(32'h800);
      answer(2, 32'h900, 32'h100, 32'h0);
      wait_uvalid(20, lat);
      exp_u = exp_q.pop_front();
      n_checks++;
      if (lat != LAT || u_out !== exp_u) begin
         n_fail++; $display("FAIL en_resume_u: got u=%0h lat=%0d want %0h/%0d", u_out, lat, exp_u, LAT);
      end
      $display("en_drop: resumed after %0d cycles, u_out=%0h", n, u_out);
   endtask

   task automatic test_async_reset;
      bit got;
      int n;
      wait_req(150, got);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({sns_req, u_valid, fault} !== 3'b000 || overrun !== 8'd0) begin
         n_fail++; $display("FAIL async_reset_flags: got req/uv/fault=%b ov=%0d want 000/0",
                            {sns_req, u_valid, fault}, overrun);
      end
      n_checks++;
      if (u_out !== 32'd0 || c_thd !== 32'd0 || c_th !== 32'd0) begin
         n_fail++; $display("FAIL async_reset_data: got u=%0h thd=%0h th=%0h want 0", u_out, c_thd, c_th);
      end
      @(negedge clk);
      rst_n = 1'b1;
      n = -1;
      for (int i = 1; i <= 150 && n < 0; i++) begin
         @(negedge clk);
         if (sns_req) n = i;
      end
      n_checks++;
      if (n != PERIOD) begin n_fail++; $display("FAIL async_reset_restart: got %0d want %0d", n, PERIOD); end
      $display("async_reset: got_req_before=%b restart after %0d cycles", got, n);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_saturation();
      test_timeout();
      test_overrun();
      test_en_drop();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
